// File: rtl/led_share_sched.sv
// Round-robin time-slot scheduler sharing one RGB LED between NREQ requesters.
// Each owner shows its latched colour as PWM for a fixed slot; a dark gap separates different owners.
module led_share_sched #(
   parameter int unsigned NREQ        = 2,
   parameter int unsigned PWM_BITS    = 8,
   parameter int unsigned SLOT_CYCLES = 4800000,
   parameter int unsigned GAP_CYCLES  = 480000
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NREQ-1:0]            req,
   input  logic [NREQ*3*PWM_BITS-1:0] colour,
   output logic [NREQ-1:0]            grant,
   output logic                       red_pwm,
   output logic                       green_pwm,
   output logic                       blue_pwm,
   output logic                       busy
);
   localparam int unsigned CMAX = (SLOT_CYCLES > GAP_CYCLES) ? SLOT_CYCLES : GAP_CYCLES;
   localparam int unsigned CW   = $clog2(CMAX + 1);
   localparam int unsigned IW   = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int unsigned DW   = 3 * PWM_BITS;

   typedef enum logic [1:0] {IDLE, SHOW, GAP} state_t;

   state_t              state, nstate;
   logic [CW-1:0]       cnt, ncnt;
   logic [PWM_BITS-1:0] p, pn;
   logic [DW-1:0]       duty, nduty;
   logic [IW-1:0]       last_owner, win;
   logic                found, load, owner_req, others;
   int unsigned         idx;

   // Search starts just after the last owner, so a requesting index is never skipped.
   always_comb begin
      found = 1'b0;
      win   = '0;
      idx   = 0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         idx = (32'(last_owner) + 32'd1 + i) % NREQ;
         if (!found && req[IW'(idx)]) begin
            found = 1'b1;
            win   = IW'(idx);
         end
      end
   end

   assign owner_req = |(req & grant);
   assign others    = |(req & ~grant);

   always_comb begin
      nstate = state;
      ncnt   = cnt + 1'b1;
      load   = 1'b0;
      case (state)
         IDLE: begin
            ncnt = '0;
            if (found) begin
               nstate = SHOW;
               load   = 1'b1;
            end
         end
         SHOW: begin
            if (!owner_req || cnt == CW'(SLOT_CYCLES - 1)) begin
               ncnt = '0;
               if (others)         nstate = GAP;
               else if (owner_req) load   = 1'b1;  // sole requester: back-to-back slot, colour re-latched
               else                nstate = IDLE;
            end
         end
         GAP: begin
            if (cnt == CW'(GAP_CYCLES - 1)) begin
               ncnt = '0;
               if (found) begin
                  nstate = SHOW;
                  load   = 1'b1;
               end else begin
                  nstate = IDLE;
               end
            end
         end
         default: begin
            nstate = IDLE;
            ncnt   = '0;
         end
      endcase
   end

   assign pn    = p + 1'b1;
   assign nduty = load ? colour[win*DW +: DW] : duty;

   // Outputs are computed from next-cycle values so PWM and grant line up with the state they belong to.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= '0;
         p          <= '0;
         duty       <= '0;
         last_owner <= IW'(NREQ - 1);
         grant      <= '0;
         busy       <= 1'b0;
         red_pwm    <= 1'b0;
         green_pwm  <= 1'b0;
         blue_pwm   <= 1'b0;
      end else begin
         state <= nstate;
         cnt   <= ncnt;
         p     <= pn;
         duty  <= nduty;
         if (load) last_owner <= win;
         if (nstate == SHOW) grant <= load ? (NREQ'(1) << win) : grant;
         else                grant <= '0;
         busy      <= (nstate != IDLE);
         red_pwm   <= (nstate == SHOW) && (pn < nduty[2*PWM_BITS +: PWM_BITS]);
         green_pwm <= (nstate == SHOW) && (pn < nduty[PWM_BITS +: PWM_BITS]);
         blue_pwm  <= (nstate == SHOW) && (pn < nduty[0 +: PWM_BITS]);
      end
   end
endmodule
